// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Also holds the load-lane extraction used for aligned reads.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_UNAL = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam logic [15:0] MEM_ADDR_DEFAULT = 16'h1000;

  // Right-justify the addressed little-endian lane of an aligned read word.
  function automatic logic [31:0] load_lane(input logic [31:0] word,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size);
    case (size)
      SZ_BYTE: load_lane = {24'd0, 8'(word >> {off, 3'b000})};
      SZ_HALF: load_lane = {16'd0, off[1] ? word[31:16] : word[15:0]};
      default: load_lane = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-input round-robin arbiter with one-hot grants (bit 0 fetch, bit 1 data).
// On a tie the requester that was not granted last wins.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_d ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             last_d <= REQ_I;
    else if (gnt != 2'b00) last_d <= gnt[REQ_D];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one async_memory port between instruction fetch and load/store.
// Registers each accepted request, drives memory for 1-2 cycles, splits unaligned word reads.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [15:0] MEM_ADDR = MEM_ADDR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic [1:0]  gnt;
  logic        lat_id, lat_we, lat_err, lat_split;
  logic [1:0]  lat_size, lat_off;
  logic [31:0] lo;

  logic        d_bad, d_split, resp_now;
  logic [1:0]  d_eff_size;
  logic [31:0] resp_data;

  mem_arb_rr2 u_rr2 (
    .clock (clock),
    .reset (reset),
    .en    (state == IDLE),
    .req   ({d_req, i_req}),
    .gnt   (gnt)
  );

  assign i_gnt = gnt[REQ_I];
  assign d_gnt = gnt[REQ_D];

  always_comb begin
    d_bad = (d_size == SZ_HALF && d_addr[0])
         || (d_size == SZ_WORD && d_addr[1:0] != 2'b00)
         || (d_size == SZ_UNAL && d_we && d_addr[1:0] != 2'b00)
         || (d_we && d_addr[31:16] != MEM_ADDR);
    d_split    = !d_we && d_size == SZ_UNAL && d_addr[1:0] != 2'b00;
    // Size 2 always moves whole words on the memory side.
    d_eff_size = (d_size == SZ_UNAL) ? SZ_WORD : d_size;
    resp_now   = (state == SPLIT) || (state == ACCESS && !lat_split);
    resp_data  = (state == SPLIT) ? 32'({mem_rdata, lo} >> {lat_off, 3'b000})
                                  : load_lane(mem_rdata, lat_off, lat_size);
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_id    <= REQ_I;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_split <= 1'b0;
      lat_size  <= SZ_BYTE;
      lat_off   <= 2'b00;
      lo        <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= SZ_BYTE;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt[REQ_D]) begin
            state     <= ACCESS;
            lat_id    <= REQ_D;
            lat_we    <= d_we;
            lat_size  <= d_eff_size;
            lat_off   <= d_addr[1:0];
            lat_err   <= d_bad;
            lat_split <= d_split && !d_bad;
            mem_addr  <= d_split ? {d_addr[31:2], 2'b00} : d_addr;
            mem_wdata <= d_wdata;
            mem_size  <= d_eff_size;
            mem_we    <= d_we && !d_bad;
            mem_re    <= !d_we && !d_bad;
          end else if (gnt[REQ_I]) begin
            state     <= ACCESS;
            lat_id    <= REQ_I;
            lat_we    <= 1'b0;
            lat_size  <= SZ_WORD;
            lat_off   <= 2'b00;
            lat_err   <= 1'b0;
            lat_split <= 1'b0;
            mem_addr  <= i_addr & ~32'h3;
            mem_wdata <= '0;
            mem_size  <= SZ_WORD;
            mem_we    <= 1'b0;
            mem_re    <= 1'b1;
          end
        end
        ACCESS: begin
          if (lat_split) begin
            lo       <= mem_rdata;
            mem_addr <= mem_addr + 32'd4;
            state    <= SPLIT;
          end
        end
        default: state <= IDLE;
      endcase

      // Final memory cycle: publish the response and release the port.
      if (resp_now) begin
        state     <= IDLE;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_size  <= SZ_BYTE;
        mem_we    <= 1'b0;
        mem_re    <= 1'b0;
        if (lat_id == REQ_D) begin
          d_rvalid <= 1'b1;
          d_err    <= lat_err;
          d_rdata  <= (lat_err || lat_we) ? '0 : resp_data;
        end else begin
          i_rvalid <= 1'b1;
          i_rdata  <= resp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, hand sequences for
// arbitration/reset corners, and random traffic against a byte-level memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_size = 2'd0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_we, mem_re;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_size    (d_size),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_size  (mem_size),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  // Environment memory: 1 KB aliased window, combinational read, write on clock edge.
  logic [31:0] bmem [256];
  logic        mem_clr = 1'b1, pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  assign mem_rdata = bmem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int k = 0; k < 256; k++) bmem[k] <= '0;
    end else if (pre_we) begin
      bmem[pre_idx] <= pre_data;
    end else if (mem_we) begin
      case (mem_size)
        2'd0:    bmem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        2'd1:    bmem[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        default: bmem[mem_addr[9:2]] <= mem_wdata;
      endcase
    end
  end

  // Reference model: plain byte array, same 1 KB aliasing.
  logic [7:0] ref_mem [1024];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic we, input logic [1:0] sz, input logic [31:0] a);
    logic e;
    e = 1'b0;
    if (sz == 2'd1 && a[0]) e = 1'b1;
    if (sz == 2'd3 && a[1:0] != 2'd0) e = 1'b1;
    if (sz == 2'd2 && we && a[1:0] != 2'd0) e = 1'b1;
    if (we && a[31:16] != 16'h1000) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = r | (32'(ref_mem[10'(a + 32'(i))]) << (8 * i));
    return r;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_mem[10'(a + 32'(i))] = 8'(wd >> (8 * i));
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    @(negedge clock);
    pre_idx = a[9:2]; pre_data = w; pre_we = 1'b1;
    @(negedge clock);
    pre_we = 1'b0;
    ref_store({a[31:2], 2'b00}, 4, w);
  endtask

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_i(input logic [31:0] a, output logic [31:0] rd, output int lat,
                      output logic ok);
    logic granted;
    granted = 1'b0; ok = 1'b0; lat = 0; rd = '0;
    @(negedge clock);
    i_req = 1'b1; i_addr = a;
    for (int k = 0; k < 20 && !granted; k++) begin
      #1;
      if (i_gnt) granted = 1'b1;
      else @(negedge clock);
    end
    if (granted) begin
      for (int k = 1; k <= 6 && !ok; k++) begin
        @(negedge clock);
        if (k == 1) i_req = 1'b0;
        if (i_rvalid) begin ok = 1'b1; lat = k; rd = i_rdata; end
      end
    end
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output int nwe, output int nre,
                      output logic [1:0] msz, output logic ok);
    logic granted;
    granted = 1'b0; ok = 1'b0; lat = 0; rd = '0; er = 1'b0; nwe = 0; nre = 0; msz = '0;
    @(negedge clock);
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    for (int k = 0; k < 20 && !granted; k++) begin
      #1;
      if (d_gnt) granted = 1'b1;
      else @(negedge clock);
    end
    if (granted) begin
      for (int k = 1; k <= 6 && !ok; k++) begin
        @(negedge clock);
        if (k == 1) begin d_req = 1'b0; msz = mem_size; end
        nwe += int'(mem_we);
        nre += int'(mem_re);
        if (d_rvalid) begin ok = 1'b1; lat = k; rd = d_rdata; er = d_err; end
      end
    end
    d_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t tbl [21];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er, ok, seen;
    logic [1:0]  msz;
    int          lat, nwe, nre;

    tbl[0]  = '{1'b1, SZ_WORD, 32'h1000_0020, 32'h4433_2211, 1'b0, 32'h0,          2};
    tbl[1]  = '{1'b1, SZ_WORD, 32'h1000_0024, 32'h8877_6655, 1'b0, 32'h0,          2};
    tbl[2]  = '{1'b0, SZ_UNAL, 32'h1000_0021, 32'h0,         1'b0, 32'h5544_3322,  3};
    tbl[3]  = '{1'b0, SZ_HALF, 32'h1000_0022, 32'h0,         1'b0, 32'h0000_4433,  2};
    tbl[4]  = '{1'b0, SZ_BYTE, 32'h1000_0021, 32'h0,         1'b0, 32'h0000_0022,  2};
    tbl[5]  = '{1'b0, SZ_UNAL, 32'h1000_0023, 32'h0,         1'b0, 32'h7766_5544,  3};
    tbl[6]  = '{1'b0, SZ_UNAL, 32'h1000_0024, 32'h0,         1'b0, 32'h8877_6655,  2};
    tbl[7]  = '{1'b1, SZ_BYTE, 32'h1000_0013, 32'h1234_56A5, 1'b0, 32'h0,          2};
    tbl[8]  = '{1'b0, SZ_BYTE, 32'h1000_0013, 32'h0,         1'b0, 32'h0000_00A5,  2};
    tbl[9]  = '{1'b1, SZ_WORD, 32'h1000_0002, 32'h1111_1111, 1'b1, 32'h0,          2};
    tbl[10] = '{1'b1, SZ_WORD, 32'h2000_0000, 32'h2222_2222, 1'b1, 32'h0,          2};
    tbl[11] = '{1'b0, SZ_HALF, 32'h1000_0021, 32'h0,         1'b1, 32'h0,          2};
    tbl[12] = '{1'b1, SZ_UNAL, 32'h1000_0025, 32'h3333_3333, 1'b1, 32'h0,          2};
    tbl[13] = '{1'b1, SZ_UNAL, 32'h1000_0028, 32'hCAFE_F00D, 1'b0, 32'h0,          2};
    tbl[14] = '{1'b0, SZ_WORD, 32'h1000_0028, 32'h0,         1'b0, 32'hCAFE_F00D,  2};
    tbl[15] = '{1'b1, SZ_HALF, 32'h1000_002A, 32'h0000_BEEF, 1'b0, 32'h0,          2};
    tbl[16] = '{1'b0, SZ_WORD, 32'h1000_0028, 32'h0,         1'b0, 32'hBEEF_F00D,  2};
    tbl[17] = '{1'b1, SZ_WORD, 32'h1000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0,          2};
    tbl[18] = '{1'b1, SZ_WORD, 32'h1000_0000, 32'h0BAD_BEEF, 1'b0, 32'h0,          2};
    tbl[19] = '{1'b0, SZ_UNAL, 32'hFFFF_FFFE, 32'h0,         1'b0, 32'hBEEF_CAFE,  3};
    tbl[20] = '{1'b0, SZ_WORD, 32'h1000_0022, 32'h0,         1'b1, 32'h0,          2};

    for (int k = 0; k < 1024; k++) ref_mem[k] = 8'h00;

    // Reset state
    repeat (2) @(negedge clock);
    mem_clr = 1'b0;
    check("rst_flags", {i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, mem_we, mem_re}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_size", 32'(mem_size), 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);

    // Both requesters held from reset: D, I, D, I every second cycle
    i_req = 1'b1; i_addr = 32'h1000_0008;
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_addr = 32'h1000_000C;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("alt_d_gnt_c%0d", c), 32'(d_gnt), 32'((c % 4) == 0));
      check($sformatf("alt_i_gnt_c%0d", c), 32'(i_gnt), 32'((c % 4) == 2));
      @(negedge clock);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clock);

    // Single fetch timing
    preload(32'h1000_0004, 32'hDEAD_BEEF);
    @(negedge clock);
    i_req = 1'b1; i_addr = 32'h1000_0004;
    #1;
    check("fetch_gnt", 32'(i_gnt), 32'h1);
    @(negedge clock);
    i_req = 1'b0;
    check("fetch_mem_re", {31'd0, mem_re}, 32'h1);
    check("fetch_mem_addr", mem_addr, 32'h1000_0004);
    @(negedge clock);
    check("fetch_rvalid", 32'(i_rvalid), 32'h1);
    check("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
    check("fetch_no_d_rvalid", 32'(d_rvalid), 32'h0);

    // Fetch with low address bits set reads the enclosing word
    do_i(32'h1000_0007, rd, lat, ok);
    check("fetch2_done", 32'(ok), 32'h1);
    check("fetch2_rdata", rd, 32'hDEAD_BEEF);

    // Directed data vectors
    for (int v = 0; v < 21; v++) begin
      do_d(tbl[v].we, tbl[v].size, tbl[v].addr, tbl[v].wdata, rd, er, lat, nwe, nre, msz, ok);
      check($sformatf("v%0d_done", v), 32'(ok), 32'h1);
      check($sformatf("v%0d_err", v), 32'(er), 32'(tbl[v].err));
      check($sformatf("v%0d_rdata", v), rd, tbl[v].rdata);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(tbl[v].lat));
      check($sformatf("v%0d_we_cycles", v), 32'(nwe), 32'(tbl[v].we && !tbl[v].err));
      check($sformatf("v%0d_re_cycles", v), 32'(nre),
            (tbl[v].we || tbl[v].err) ? 32'd0 : 32'(tbl[v].lat - 1));
      if (!tbl[v].err)
        check($sformatf("v%0d_mem_size", v), 32'(msz),
              32'((tbl[v].size == SZ_UNAL) ? SZ_WORD : tbl[v].size));
      if (tbl[v].we && !tbl[v].err) ref_store(tbl[v].addr, nbytes(tbl[v].size), tbl[v].wdata);
    end

    // Reset asserted during the SPLIT cycle drops the transaction
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_UNAL; d_addr = 32'h1000_0021;
    #1;
    check("sr_gnt", 32'(d_gnt), 32'h1);
    @(negedge clock);
    d_req = 1'b0;
    @(negedge clock);
    check("sr_split_re", {31'd0, mem_re}, 32'h1);
    check("sr_split_addr", mem_addr, 32'h1000_0024);
    reset = 1'b1;
    #1;
    check("sr_rst_mem", {mem_addr[31:2], mem_re, mem_we}, 32'h0);
    check("sr_rst_rvalid", {30'd0, d_rvalid, i_rvalid}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (d_rvalid || i_rvalid) seen = 1'b1;
    end
    check("sr_no_rvalid", 32'(seen), 32'h0);
    do_d(1'b0, SZ_WORD, 32'h1000_0020, 32'h0, rd, er, lat, nwe, nre, msz, ok);
    check("sr_after_done", 32'(ok), 32'h1);
    check("sr_after_rdata", rd, 32'h4433_2211);
    check("sr_after_latency", 32'(lat), 32'd2);

    // Random traffic against the byte-level model
    for (int t = 0; t < 200; t++) begin
      logic        we, exp_err;
      logic [1:0]  sz;
      logic [15:0] hi;
      logic [31:0] a, wd, exp_rd;
      int          exp_lat;
      if ($urandom_range(0, 3) == 0) begin
        a = {16'h1000, 6'd0, 10'($urandom)};
        do_i(a, rd, lat, ok);
        check($sformatf("r%0d_i_done", t), 32'(ok), 32'h1);
        check($sformatf("r%0d_i_rdata", t), rd, ref_load({a[31:2], 2'b00}, 4));
        check($sformatf("r%0d_i_latency", t), 32'(lat), 32'd2);
      end else begin
        we = 1'($urandom_range(0, 1));
        sz = 2'($urandom);
        hi = ($urandom_range(0, 7) == 0) ? 16'h2000 : 16'h1000;
        a  = {hi, 6'd0, 10'($urandom)};
        wd = $urandom;
        exp_err = ref_err(we, sz, a);
        exp_rd  = (exp_err || we) ? 32'h0 : ref_load(a, nbytes(sz));
        exp_lat = (!exp_err && !we && sz == SZ_UNAL && a[1:0] != 2'd0) ? 3 : 2;
        do_d(we, sz, a, wd, rd, er, lat, nwe, nre, msz, ok);
        check($sformatf("r%0d_d_done", t), 32'(ok), 32'h1);
        check($sformatf("r%0d_d_err", t), 32'(er), 32'(exp_err));
        check($sformatf("r%0d_d_rdata", t), rd, exp_rd);
        check($sformatf("r%0d_d_latency", t), 32'(lat), 32'(exp_lat));
        check($sformatf("r%0d_d_we_cycles", t), 32'(nwe), 32'(we && !exp_err));
        if (we && !exp_err) ref_store(a, nbytes(sz), wd);
      end
    end

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
